// File: rtl/booth_r4_multiplier_32x32_if.sv
// booth_r4_multiplier_32x32_if: start/done handshake bundle, shared in shape with the SRT divider.
interface booth_r4_multiplier_32x32_if #(parameter int WIDTH = 32);
    logic start, is_signed, busy, done;
    logic [WIDTH-1:0] multiplicand_in, multiplier_in;
    logic [2*WIDTH-1:0] product_out;
    modport master (output start, is_signed, multiplicand_in, multiplier_in, input busy, done, product_out);
    modport slave (input start, is_signed, multiplicand_in, multiplier_in, output busy, done, product_out);
endinterface

// File: rtl/booth_r4_multiplier_32x32.sv
// booth_r4_multiplier_32x32: sequential radix-4 Booth multiplier, one digit per cycle into a carry-save pair.
module booth_r4_multiplier_32x32 #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    booth_r4_multiplier_32x32_if.slave bus
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int P = 2 * WIDTH + 2;
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [P-1:0] sum, carry, mc, mag, pp, sum_n, carry_n;
    logic [WIDTH+2:0] mr;
    logic one, two, neg;
    // Carry comes out pre-shifted; cin fills the free LSB so a negation's +1 costs no adder.
    function automatic logic [2*P-1:0] csa_3_2(input logic [P-1:0] a, b, c, input logic cin);
        return {a ^ b ^ c, a[P-2:0] & b[P-2:0] | a[P-2:0] & c[P-2:0] | b[P-2:0] & c[P-2:0], cin};
    endfunction
    always_comb begin
        one = mr[0] ^ mr[1];
        two = (mr[2:0] == 3'b011) || (mr[2:0] == 3'b100);
        neg = mr[2] & ~(mr[1] & mr[0]);
        mag = two ? mc << 1 : one ? mc : '0;
        pp = neg ? ~mag : mag;
    end
    assign {sum_n, carry_n} = csa_3_2(sum, carry, pp, neg);
    // mc is kept pre-aligned to the current digit; mr shifts so its low 3 bits are the Booth window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            sum <= '0;
            carry <= '0;
            mc <= '0;
            mr <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.product_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    mc <= {{(P-WIDTH){bus.is_signed & bus.multiplicand_in[WIDTH-1]}}, bus.multiplicand_in};
                    mr <= {{2{bus.is_signed & bus.multiplier_in[WIDTH-1]}}, bus.multiplier_in, 1'b0};
                    sum <= '0;
                    carry <= '0;
                    cnt <= '0;
                    bus.busy <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    sum <= sum_n;
                    carry <= carry_n;
                    mc <= mc << 2;
                    mr <= {{2{mr[WIDTH+2]}}, mr[WIDTH+2:2]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= FINISH;
                end
                FINISH: begin
                    bus.product_out <= sum[2*WIDTH-1:0] + carry[2*WIDTH-1:0];
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_multiplier_32x32.sv
// tb_booth_r4_multiplier_32x32: directed and random checks of the Booth multiplier against plain arithmetic.
module tb_booth_r4_multiplier_32x32;
    logic clk = 1'b0, rst_n = 1'b0;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    booth_r4_multiplier_32x32_if bus ();
    booth_r4_multiplier_32x32 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        return s ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'b0, a} * {32'b0, b};
    endfunction
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] p, output int lat, output logic busy_acc, output logic busy_done);
        @(negedge clk);
        bus.multiplicand_in = a;
        bus.multiplier_in = b;
        bus.is_signed = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_acc = bus.busy;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
        p = bus.done ? bus.product_out : 64'd0;
        busy_done = bus.busy;
    endtask
    initial begin
        logic [63:0] p, hold;
        logic ba, bd;
        int lat, dones, badlat;
        int dd, dv, q, r;
        logic [31:0] a, b;
        logic s;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.multiplicand_in = '0;
        bus.multiplier_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_prod", bus.product_out, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op(32'd100, 32'd10, 1'b1, p, lat, ba, bd);
        chk("100x10", p, 64'd1000);
        chk("lat_first", 64'(lat), 64'd18);
        chk("busy_after_accept", 64'(ba), 64'd1);
        chk("busy_in_done", 64'(bd), 64'd0);
        run_op(32'hFFFF_FFF9, 32'd6, 1'b1, p, lat, ba, bd);
        chk("m7x6", p, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, p, lat, ba, bd);
        chk("min_sq", p, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, ba, bd);
        chk("umax_sq", p, 64'hFFFF_FFFE_0000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, lat, ba, bd);
        chk("m1_sq", p, 64'd1);
        run_op(32'd0, $urandom, 1'b1, p, lat, ba, bd);
        chk("zero", p, 64'd0);
        chk("lat_zero", 64'(lat), 64'd18);
        // A start pulse with new operands while busy must neither retrigger nor disturb the running product.
        @(negedge clk);
        bus.multiplicand_in = 32'd12345;
        bus.multiplier_in = 32'd3;
        bus.is_signed = 1'b1;
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.multiplicand_in = 32'd5;
        bus.multiplier_in = 32'd5;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        dones = 0;
        p = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                p = bus.product_out;
            end
        end
        chk("ignore_dones", 64'(dones), 64'd1);
        chk("ignore_prod", p, 64'd37035);
        @(negedge clk);
        bus.multiplicand_in = 32'd77;
        bus.multiplier_in = 32'd99;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_prod", bus.product_out, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        run_op(32'd2, 32'd3, 1'b1, p, lat, ba, bd);
        chk("after_abort", p, 64'd6);
        chk("lat_after_abort", 64'(lat), 64'd18);
        // Start held high: the second op is accepted in the first op's done cycle.
        @(negedge clk);
        bus.multiplicand_in = 32'd1000;
        bus.multiplier_in = 32'd1000;
        bus.is_signed = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (lat < 50 && !bus.done) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat1", 64'(lat), 64'd18);
        chk("b2b_prod1", bus.product_out, 64'd1000000);
        bus.multiplicand_in = 32'd7;
        bus.multiplier_in = 32'd9;
        lat = 0;
        hold = '0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) hold = bus.product_out;
            if (bus.done) break;
        end
        bus.start = 1'b0;
        chk("b2b_hold", hold, 64'd1000000);
        chk("b2b_period", 64'(lat), 64'd19);
        chk("b2b_prod2", bus.done ? bus.product_out : 64'd0, 64'd63);
        badlat = 0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, p, lat, ba, bd);
            if (lat != 18) badlat++;
            chk("rand", p, ref_mul(a, b, s));
        end
        for (int i = 0; i < 2000; i++) begin
            do begin
                dd = int'($urandom);
                dv = int'($urandom) >>> $urandom_range(0, 30);
            end while (dv == 0 || (dd == int'(32'h8000_0000) && dv == -1));
            q = dd / dv;
            r = dd % dv;
            run_op(q, dv, 1'b1, p, lat, ba, bd);
            if (lat != 18) badlat++;
            chk("roundtrip", {32'b0, p[31:0] + 32'(r)}, {32'b0, 32'(dd)});
        end
        chk("lat_all", 64'(badlat), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
